// File: rtl/pu_spi_pkg.sv
// Shared state encoding and helpers for the SPI processing-unit slave front end.
package pu_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_RDY0,
    S_RDY1,
    S_RELOAD
  } spi_state_t;

  // Length of the word strobe that pu_buffer needs for its save/emit pair.
  localparam int READY_CYCLES = 2;

  function automatic int bit_cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/pu_spi_sync.sv
// Multi-flop synchronizer for one asynchronous line, with edge pulses taken
// from the synchronized output and one further history flop.
module pu_spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      last_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~last_q;
  assign fall = ~q & last_q;

endmodule

// File: rtl/pu_spi_slave_driver.sv
// SPI mode-0 slave serializer feeding pu_buffer with a two-cycle ready strobe.
// Build option: define PU_SPI_MISO_TRISTATE_EN to float miso while not busy.
module pu_spi_slave_driver
  import pu_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy
);

  localparam int              CNT_W    = bit_cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_q;

  pu_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // cs idles high, so its chain resets high to keep busy low out of reset.
  pu_spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  logic unused_sync;
  assign unused_sync = sclk_q ^ cs_fall;

  // mosi is taken from the same stage as the sclk edge so the bit lines up with its rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync <= '0;
    else      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  spi_state_t            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  abort_q, abort_d;

  // NOTE: the shift registers are reset with everything else so miso is defined from the first busy cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      data_out_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      data_out_q <= data_out_d;
      abort_q    <= abort_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    data_out_d = data_out_q;
    abort_d    = abort_q;

    unique case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        abort_d   = 1'b0;
        if (!cs_q) begin
          tx_sh_d = data_in;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (cs_q) begin
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_q};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d  = '0;
            data_out_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_q};
            state_d    = S_RDY0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall && (bit_cnt_q != '0)) begin
          // The fall after the last bit leaves tx_sh alone; the reload refills it.
          tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
        end
      end

      S_RDY0: begin
        if (cs_rise) abort_d = 1'b1;
        state_d = S_RDY1;
      end

      S_RDY1: begin
        abort_d = 1'b0;
        state_d = (abort_q || cs_rise || cs_q) ? S_IDLE : S_RELOAD;
      end

      S_RELOAD: begin
        tx_sh_d = data_in;
        state_d = S_SHIFT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign data_out = data_out_q;
  assign ready    = (state_q == S_RDY0) || (state_q == S_RDY1);
  assign busy     = ~cs_q;

`ifdef PU_SPI_MISO_TRISTATE_EN
  assign miso = busy ? tx_sh_q[DATA_WIDTH-1] : 1'bz;
`else
  assign miso = busy ? tx_sh_q[DATA_WIDTH-1] : 1'b0;
`endif

endmodule

// File: tb/tb_pu_spi_slave_driver.sv
// Directed self-checking bench for pu_spi_slave_driver (mode-0 master, 8-clk half period).
module tb_pu_spi_slave_driver;

  localparam int W    = 8;
  localparam int SS   = 2;
  localparam int HALF = 8;

`ifdef PU_SPI_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         ready;
  logic         busy;

  int checks = 0;
  int errors = 0;

  pu_spi_slave_driver #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts completed ready pulses and any whose width is not 2.
  int ready_pulses = 0;
  int ready_run    = 0;
  int bad_widths   = 0;
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_run++;
    end else if (ready_run != 0) begin
      ready_pulses++;
      if (ready_run != 2) bad_widths++;
      ready_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: plain word; 1: raise cs one clk after the last rise; 2: reset when ready appears.
  task automatic spi_xfer(input logic [W-1:0] tx, input int nbits, input int mode, input bit echo,
                          output logic [W-1:0] rx_miso, output int lat);
    lat     = 0;
    rx_miso = '0;
    for (int b = 0; b < nbits; b++) begin
      mosi = tx[W-1-b];
      repeat (HALF) @(negedge clk);
      rx_miso = {rx_miso[W-2:0], miso};
      sclk = 1'b1;
      for (int c = 1; c <= HALF; c++) begin
        @(posedge clk);
        #1;
        if (c == 1 && mode == 1 && b == nbits - 1) cs = 1'b1;
        if (ready === 1'b1 && lat == 0) begin
          lat = c;
          if (echo) data_in = tx;
          if (mode == 2) begin
            #1;
            rst = 1'b0;
            cs  = 1'b1;
            #1;
            check("rst_async_ready", {31'd0, ready}, 32'd0);
            check("rst_async_data_out", {24'd0, data_out}, 32'd0);
            check("rst_async_busy", {31'd0, busy}, 32'd0);
          end
        end
      end
      @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  logic [W-1:0] mw;
  int           lat;
  int           p0;

  initial begin
    rst     = 1'b0;
    sclk    = 1'b0;
    cs      = 1'b1;
    mosi    = 1'b0;
    data_in = 8'h3C;
    repeat (3) @(negedge clk);
    check("reset_data_out", {24'd0, data_out}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_miso", {31'd0, miso}, {31'd0, MISO_IDLE});
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single word 0xA5 in, 0x3C out, with latency measured from the last rise.
    p0 = ready_pulses;
    cs = 1'b0;
    spi_xfer(8'hA5, 8, 0, 1'b0, mw, lat);
    check("t1_data_out", {24'd0, data_out}, 32'h0000_00A5);
    check("t1_miso_word", {24'd0, mw}, 32'h0000_003C);
    check("t1_latency", lat, 32'd3);
    check("t1_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check("t1_pulses", ready_pulses - p0, 32'd1);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // Back-to-back words with an echoing buffer whose reset content is zero.
    p0      = ready_pulses;
    data_in = 8'h00;
    cs      = 1'b0;
    spi_xfer(8'h01, 8, 0, 1'b1, mw, lat);
    check("t2_w0_data_out", {24'd0, data_out}, 32'h0000_0001);
    check("t2_w0_miso", {24'd0, mw}, 32'h0000_0000);
    spi_xfer(8'h02, 8, 0, 1'b1, mw, lat);
    check("t2_w1_data_out", {24'd0, data_out}, 32'h0000_0002);
    check("t2_w1_miso", {24'd0, mw}, 32'h0000_0001);
    spi_xfer(8'h03, 8, 0, 1'b1, mw, lat);
    check("t2_w2_data_out", {24'd0, data_out}, 32'h0000_0003);
    check("t2_w2_miso", {24'd0, mw}, 32'h0000_0002);
    repeat (4) @(negedge clk);
    check("t2_pulses", ready_pulses - p0, 32'd3);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // Partial word aborted by cs, then a clean 0x55.
    p0 = ready_pulses;
    cs = 1'b0;
    spi_xfer(8'hFF, 5, 0, 1'b0, mw, lat);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    check("t3_abort_pulses", ready_pulses - p0, 32'd0);
    check("t3_abort_busy", {31'd0, busy}, 32'd0);
    check("t3_abort_data_out", {24'd0, data_out}, 32'h0000_0003);
    cs = 1'b0;
    spi_xfer(8'h55, 8, 0, 1'b0, mw, lat);
    check("t3_data_out", {24'd0, data_out}, 32'h0000_0055);
    check("t3_miso_word", {24'd0, mw}, 32'h0000_0003);
    repeat (4) @(negedge clk);
    check("t3_pulses", ready_pulses - p0, 32'd1);
    cs = 1'b1;
    repeat (6) @(negedge clk);

    // cs rises while the strobe is in its first cycle.
    p0 = ready_pulses;
    cs = 1'b0;
    spi_xfer(8'h96, 8, 1, 1'b0, mw, lat);
    repeat (4) @(negedge clk);
    check("t4_data_out", {24'd0, data_out}, 32'h0000_0096);
    check("t4_pulses", ready_pulses - p0, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_miso_idle", {31'd0, miso}, {31'd0, MISO_IDLE});
    repeat (6) @(negedge clk);

    // Reset asserted mid-strobe, between clock edges.
    cs = 1'b0;
    spi_xfer(8'h5A, 8, 2, 1'b0, mw, lat);
    check("t5_strobe_reached", lat, 32'd3);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_after_ready", {31'd0, ready}, 32'd0);
    check("t5_after_busy", {31'd0, busy}, 32'd0);

    // One more word, then sclk activity with cs high must be ignored.
    data_in = 8'hE7;
    cs      = 1'b0;
    spi_xfer(8'hC3, 8, 0, 1'b0, mw, lat);
    check("t6_data_out", {24'd0, data_out}, 32'h0000_00C3);
    check("t6_miso_word", {24'd0, mw}, 32'h0000_00E7);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    p0 = ready_pulses;
    for (int t = 0; t < 16; t++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      repeat (4) @(negedge clk);
      if (ready === 1'b1) p0 = p0 - 100;
    end
    repeat (8) @(negedge clk);
    check("t6_idle_data_out", {24'd0, data_out}, 32'h0000_00C3);
    check("t6_idle_pulses", ready_pulses - p0, 32'd0);
    check("t6_idle_miso", {31'd0, miso}, {31'd0, MISO_IDLE});
    check("t6_idle_busy", {31'd0, busy}, 32'd0);

    check("strobe_width_all", bad_widths, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
